sdram_port_arbiter: RTL

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one SDRAM controller port, with a watchdog timeout.
// Optional round-robin between fetch and data when SDRAM_ARB_RR_EN is defined; otherwise fixed priority.
module sdram_port_arbiter #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    // fetch port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    // data port
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_size,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    // downstream controller
    output logic        m_rd,
    output logic        m_wr,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [2:0]  m_size,
    input  logic [31:0] m_rdata,
    input  logic        m_rd_valid,
    input  logic        m_wr_valid,
    input  logic        m_init,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DREAD,
        ST_DWRITE,
        ST_GAP
    } state_t;

    localparam logic [2:0]  SIZE_WORD = 3'b010;
    localparam logic [15:0] WD_LAST   = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] wd_cnt;
    logic        grant_f;
    logic        grant_dr;
    logic        grant_dw;
    logic        done;
    logic        expire;
    logic        in_grant;

`ifdef SDRAM_ARB_RR_EN
    logic        last_data;
`endif

    assign in_grant = (state == ST_FETCH) || (state == ST_DREAD) || (state == ST_DWRITE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_f   = 1'b0;
        grant_dr  = 1'b0;
        grant_dw  = 1'b0;
        done      = 1'b0;
        expire    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (m_init) begin
`ifdef SDRAM_ARB_RR_EN
                    // Contention: alternate against whoever owned the port last.
                    if ((d_wr || d_rd) && i_req) begin
                        if (last_data) begin
                            grant_f = 1'b1;
                        end else if (d_wr) begin
                            grant_dw = 1'b1;
                        end else begin
                            grant_dr = 1'b1;
                        end
                    end else if (d_wr) begin
                        grant_dw = 1'b1;
                    end else if (d_rd) begin
                        grant_dr = 1'b1;
                    end else if (i_req) begin
                        grant_f = 1'b1;
                    end
`else
                    if (d_wr) begin
                        grant_dw = 1'b1;
                    end else if (d_rd) begin
                        grant_dr = 1'b1;
                    end else if (i_req) begin
                        grant_f = 1'b1;
                    end
`endif
                end
                if (grant_dw) begin
                    state_nxt = ST_DWRITE;
                end else if (grant_dr) begin
                    state_nxt = ST_DREAD;
                end else if (grant_f) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH, ST_DREAD: begin
                if (m_rd_valid) begin
                    done = 1'b1;
                end else if (wd_cnt == WD_LAST) begin
                    expire = 1'b1;
                end
            end
            ST_DWRITE: begin
                if (m_wr_valid) begin
                    done = 1'b1;
                end else if (wd_cnt == WD_LAST) begin
                    expire = 1'b1;
                end
            end
            ST_GAP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (done || expire) begin
            state_nxt = ST_GAP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rd    <= 1'b0;
            m_wr    <= 1'b0;
            m_addr  <= 32'h0;
            m_wdata <= 32'h0;
            m_size  <= SIZE_WORD;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            i_rdata <= 32'h0;
            d_rdata <= 32'h0;
            err     <= 1'b0;
            wd_cnt  <= 16'h0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;

            if (grant_f) begin
                m_rd   <= 1'b1;
                m_addr <= i_addr;
                m_size <= SIZE_WORD;
                wd_cnt <= 16'h0;
            end else if (grant_dr) begin
                m_rd   <= 1'b1;
                m_addr <= d_addr;
                m_size <= d_size;
                wd_cnt <= 16'h0;
            end else if (grant_dw) begin
                m_wr    <= 1'b1;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
                m_size  <= d_size;
                wd_cnt  <= 16'h0;
            end else if (in_grant) begin
                wd_cnt <= wd_cnt + 16'd1;
            end

            // A watchdog expiry looks like a completion with zero read data.
            if (done || expire) begin
                m_rd <= 1'b0;
                m_wr <= 1'b0;
                if (state == ST_FETCH) begin
                    i_ack   <= 1'b1;
                    i_rdata <= expire ? 32'h0 : m_rdata;
                end else begin
                    d_ack   <= 1'b1;
                    d_rdata <= expire ? 32'h0 : m_rdata;
                end
            end

            if (expire) begin
                err <= 1'b1;
            end
        end
    end

`ifdef SDRAM_ARB_RR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_data <= 1'b1;
        end else if (grant_f) begin
            last_data <= 1'b0;
        end else if (grant_dr || grant_dw) begin
            last_data <= 1'b1;
        end
    end
`endif

endmodule
